// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding,
// default operand width and the bit-counter width helper.
package mult_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TEST  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter must hold 0..n-1; a single-iteration multiplier still gets one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_controller_if.sv
// Handshake to the surrounding system plus strobe/feedback wires to the
// shift-add datapath. The controller is the master side.
interface shift_add_controller_if;
    logic start_i;
    logic M_i;
    logic load_o;
    logic sh_o;
    logic ad_o;
    logic busy_o;
    logic done_o;

    modport master (
        input  start_i, M_i,
        output load_o, sh_o, ad_o, busy_o, done_o
    );

    modport slave (
        output start_i, M_i,
        input  load_o, sh_o, ad_o, busy_o, done_o
    );
endinterface

// File: rtl/shift_add_controller.sv
// Control FSM for the N-bit unsigned shift-add multiplier datapath.
// Walks the multiplier LSB-first: TEST adds when M is set (then SHIFT),
// otherwise shifts directly; after N shifts it pulses done for one cycle.
module shift_add_controller
    import mult_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shift_add_controller_if.master  bus
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           load, sh, ad, busy, done;

    // State and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter step and strobe decode. Only one strobe is ever
    // raised per state branch, which keeps the datapath priority irrelevant.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        sh        = 1'b0;
        ad        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                load = bus.start_i;
                if (bus.start_i) begin
                    state_nxt = TEST;
                    cnt_nxt   = '0;
                end
            end
            TEST: begin
                if (bus.M_i) begin
                    ad        = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    sh = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = TEST;
                    end
                end
            end
            SHIFT: begin
                sh = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = TEST;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load is Mealy on start_i; gating with rst_n keeps it low while reset
    // is held even if start_i is high. Other strobes are already 0 in IDLE.
    assign bus.load_o = load & rst_n;
    assign bus.sh_o   = sh;
    assign bus.ad_o   = ad;
    assign bus.busy_o = busy;
    assign bus.done_o = done;

endmodule

// File: tb/tb_shift_add_controller.sv
// Bench for shift_add_controller: a behavioural datapath closes the M
// feedback loop; expected strobe sequences, done timing and products are
// derived from the multiplier bits and plain multiplication.
module tb_shift_add_controller;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic [3:0] mplier;
    logic [3:0] mcand;
    logic [8:0] acc;
    int npass;
    int ntot;

    shift_add_controller_if bus();

    shift_add_controller #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: ad > sh > load priority, accumulator upper half
    // takes the add, whole register shifts right, product in acc[7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          acc <= '0;
        else if (bus.ad_o)   acc[8:4] <= {1'b0, acc[7:4]} + {1'b0, mcand};
        else if (bus.sh_o)   acc <= acc >> 1;
        else if (bus.load_o) acc <= {5'b0, mplier};
    end
    assign bus.M_i = acc[0];

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b1;
        mplier = '0;
        mcand  = '0;
        #12;
        ntot++;
        if ({bus.load_o, bus.sh_o, bus.ad_o, bus.busy_o, bus.done_o} !== 5'b0)
            $display("FAIL reset_outputs got=%b want=00000",
                     {bus.load_o, bus.sh_o, bus.ad_o, bus.busy_o, bus.done_o});
        else npass++;
        @(negedge clk);
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        ntot++;
        if (bus.busy_o !== 1'b0 || bus.load_o !== 1'b0)
            $display("FAIL reset_idle busy=%b load=%b want 0 0", bus.busy_o, bus.load_o);
        else npass++;
    endtask

    // One multiplication started at a negedge (cycle 0 = IDLE with start high).
    // Strobes are predicted as L, then per multiplier bit A,S or S.
    task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                            input string tag, input bit pulse_ign);
        logic [2:0] exp_q[$];   // {ad, sh, load}
        logic [2:0] got;
        int last;
        exp_q = {};
        exp_q.push_back(3'b001);
        for (int i = 0; i < N; i++) begin
            if (a[i]) exp_q.push_back(3'b100);
            exp_q.push_back(3'b010);
        end
        last = exp_q.size();    // done cycle = 1 + N + popcount(a)

        @(negedge clk);
        mplier = a;
        mcand  = b;
        bus.start_i = 1'b1;
        #1;
        ntot++;
        if (bus.load_o !== 1'b1) $display("FAIL %s load_c0 got=%b want=1", tag, bus.load_o);
        else npass++;

        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = pulse_ign && (c == 3 || c == 6);
            @(negedge clk);
            got = {bus.ad_o, bus.sh_o, bus.load_o};
            ntot++;
            if ($countones(got) > 1) $display("FAIL %s onehot c=%0d got=%b", tag, c, got);
            else npass++;
            if (c < last) begin
                ntot++;
                if (got !== exp_q[c] || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1)
                    $display("FAIL %s strobe c=%0d got=%b done=%b busy=%b want=%b done=0 busy=1",
                             tag, c, got, bus.done_o, bus.busy_o, exp_q[c]);
                else npass++;
            end else begin
                ntot++;
                if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || got !== 3'b000)
                    $display("FAIL %s done c=%0d done=%b busy=%b strobes=%b want 1 1 000",
                             tag, c, bus.done_o, bus.busy_o, got);
                else npass++;
                ntot++;
                if (acc[7:0] !== 8'(a * b))
                    $display("FAIL %s product got=%0d want=%0d", tag, acc[7:0], a * b);
                else npass++;
            end
        end

        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        ntot++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.load_o !== 1'b0)
            $display("FAIL %s post_idle busy=%b done=%b load=%b want 0 0 0",
                     tag, bus.busy_o, bus.done_o, bus.load_o);
        else npass++;
    endtask

    task automatic test_directed();
        run_mult(4'd11, 4'd13, "m11x13", 1'b0);
        run_mult(4'd0,  4'd9,  "m0x9",   1'b0);
        run_mult(4'd15, 4'd15, "m15x15", 1'b0);
    endtask

    task automatic test_ignore_start();
        run_mult(4'd11, 4'd13, "ign_start", 1'b1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        mplier = 4'd15;
        mcand  = 4'd15;
        bus.start_i = 1'b1;
        @(posedge clk);          // into TEST (add)
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);          // into SHIFT
        #2;
        ntot++;
        if (bus.sh_o !== 1'b1) $display("FAIL midrst in_shift sh=%b want=1", bus.sh_o);
        else npass++;
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({bus.load_o, bus.sh_o, bus.ad_o, bus.busy_o, bus.done_o} !== 5'b0)
            $display("FAIL midrst async got=%b want=00000",
                     {bus.load_o, bus.sh_o, bus.ad_o, bus.busy_o, bus.done_o});
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ntot++;
        if (bus.busy_o !== 1'b0) $display("FAIL midrst busy_after got=%b want=0", bus.busy_o);
        else npass++;
        run_mult(4'd5, 4'd3, "after_rst", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_load;
        @(negedge clk);
        mplier = 4'd1;
        mcand  = 4'd7;
        bus.start_i = 1'b1;
        #1;
        ntot++;
        if (bus.load_o !== 1'b1) $display("FAIL b2b load_c0 got=%b want=1", bus.load_o);
        else npass++;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_done = (c == 6 || c == 13);
            exp_load = (c == 7);
            ntot++;
            if (bus.done_o !== exp_done || bus.load_o !== exp_load)
                $display("FAIL b2b c=%0d done=%b load=%b want done=%b load=%b",
                         c, bus.done_o, bus.load_o, exp_done, exp_load);
            else npass++;
            if (exp_done) begin
                ntot++;
                if (acc[7:0] !== 8'd7) $display("FAIL b2b product c=%0d got=%0d want=7", c, acc[7:0]);
                else npass++;
            end
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        ntot++;
        if (bus.busy_o !== 1'b0 || bus.load_o !== 1'b0)
            $display("FAIL b2b final busy=%b load=%b want 0 0", bus.busy_o, bus.load_o);
        else npass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand", 1'b0);
    endtask

    initial begin
        npass = 0;
        ntot  = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
